// File: rtl/traffic_pkg.sv
// Mode and FSM encodings plus the address-derived data pattern shared by generator and checker.
// Pure declarations: no latency, no flow control.
package traffic_pkg;

  typedef enum logic [1:0] {
    MODE_WRITE_ONLY = 2'd0,
    MODE_READ_CHECK = 2'd1,
    MODE_WRITE_READ = 2'd2,
    MODE_LOOP       = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // 32-bit word 'word' of the beat stored at 'adx' (adx already zero-extended to 32 bits).
  function automatic logic [31:0] pattern(input logic [31:0] adx,
                                          input logic [31:0] seed,
                                          input logic [7:0]  word);
    return seed ^ {word, 24'h0} ^ adx;
  endfunction

endpackage

// File: rtl/traffic_checker.sv
// Pops every read-buffer entry the cycle it appears and compares it against the expected pattern.
// Pop is combinational (zero latency); never backpressures the buffer, errors update next edge.
module traffic_checker
  import traffic_pkg::*;
#(
  parameter int          DATA_WIDTH = 128,
  parameter int          ADDR_WIDTH = 27,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_flight,
  input  logic                  has_return_data,
  input  logic [DATA_WIDTH-1:0] return_data,
  input  logic [ADDR_WIDTH-1:0] return_adx,
  output logic                  get_return_data,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_adx
);

  localparam int                   NW  = DATA_WIDTH / 32;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] exp_data;
  logic                  err;

  for (genvar w = 0; w < NW; w++) begin : g_exp
    assign exp_data[w*32 +: 32] = pattern(32'(return_adx), SEED, 8'(w));
  end

  assign get_return_data = has_return_data & ~reset;
  // A pop with nothing in flight is spurious and always an error.
  assign err = get_return_data & (~in_flight | (return_data != exp_data));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count     <= '0;
      first_err_adx <= '0;
    end else if (clear) begin
      err_count     <= err ? ONE : '0;
      first_err_adx <= err ? return_adx : '0;
    end else if (err) begin
      if (err_count != '1) err_count <= err_count + ONE;
      if (err_count == '0) first_err_adx <= return_adx;
    end
  end

endmodule

// File: rtl/traffic_gen_checker.sv
// DDR2 traffic generator: writes a pattern over an address range, reads it back and self-checks.
// Registered requests held until *_allowed; reads throttled at MAX_OUTSTANDING; returns popped at once.
module traffic_gen_checker
  import traffic_pkg::*;
#(
  parameter int          DATA_WIDTH      = 128,
  parameter int          ADDR_WIDTH      = 27,
  parameter int          ADDR_STEP       = 8,
  parameter int          CNT_WIDTH       = 16,
  parameter int          MAX_OUTSTANDING = 16,
  parameter logic [31:0] SEED            = 32'hA5A5_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] start_adx,
  input  logic [CNT_WIDTH-1:0]  num_xfers,
  input  logic                  write_allowed,
  input  logic                  read_allowed,
  output logic                  write_req,
  output logic                  read_req,
  output logic [DATA_WIDTH-1:0] tr_wr_data,
  output logic [ADDR_WIDTH-1:0] tr_adx,
  input  logic                  has_return_data,
  input  logic [DATA_WIDTH-1:0] return_data,
  input  logic [ADDR_WIDTH-1:0] return_adx,
  output logic                  get_return_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_adx,
  output logic [CNT_WIDTH-1:0]  pass_count
);

  localparam int                    NW    = DATA_WIDTH / 32;
  localparam int                    OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [OW-1:0]         MAX_O = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]         ONE_O = OW'(1);
  localparam logic [CNT_WIDTH-1:0]  ONE_C = CNT_WIDTH'(1);

  state_e                state;
  mode_e                 mode_q;
  logic [ADDR_WIDTH-1:0] base_adx;
  logic [ADDR_WIDTH-1:0] nxt_adx;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issued;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         outstanding_nxt;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  in_flight;
  logic                  pop_counted;
  logic                  start;

  assign wr_fire     = write_req & write_allowed;
  assign rd_fire     = read_req & read_allowed;
  assign in_flight   = (outstanding != '0);
  assign pop_counted = get_return_data & in_flight;
  assign start       = (state == ST_IDLE) & enable & (num_xfers != '0);

  for (genvar w = 0; w < NW; w++) begin : g_pat
    assign nxt_data[w*32 +: 32] = pattern(32'(nxt_adx), SEED, 8'(w));
  end

  always_comb begin
    outstanding_nxt = outstanding;
    if (rd_fire && !pop_counted)      outstanding_nxt = outstanding + ONE_O;
    else if (!rd_fire && pop_counted) outstanding_nxt = outstanding - ONE_O;
  end

  traffic_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .SEED       (SEED)
  ) u_checker (
    .clk             (clk),
    .reset           (reset),
    .clear           (start),
    .in_flight       (in_flight),
    .has_return_data (has_return_data),
    .return_data     (return_data),
    .return_adx      (return_adx),
    .get_return_data (get_return_data),
    .err_count       (err_count),
    .first_err_adx   (first_err_adx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_WRITE_ONLY;
      base_adx    <= '0;
      nxt_adx     <= '0;
      num_q       <= '0;
      issued      <= '0;
      outstanding <= '0;
      write_req   <= 1'b0;
      read_req    <= 1'b0;
      tr_adx      <= '0;
      tr_wr_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass_count  <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q   <= mode_e'(mode);
            base_adx <= start_adx;
            nxt_adx  <= start_adx;
            num_q    <= num_xfers;
            issued   <= '0;
            busy     <= 1'b1;
            state    <= (mode_e'(mode) == MODE_READ_CHECK) ? ST_READ : ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Only act once any held request has been (or is being) accepted.
          if (!(write_req && !write_allowed)) begin
            write_req <= 1'b0;
            if (!enable) begin
              state <= ST_DRAIN;
            end else if (issued == num_q) begin
              issued  <= '0;
              nxt_adx <= base_adx;
              if (mode_q == MODE_WRITE_ONLY) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_READ;
              end
            end else begin
              write_req  <= 1'b1;
              tr_adx     <= nxt_adx;
              tr_wr_data <= nxt_data;
              nxt_adx    <= nxt_adx + STEP;
              issued     <= issued + ONE_C;
            end
          end
        end
        ST_READ: begin
          if (!(read_req && !read_allowed)) begin
            read_req <= 1'b0;
            if (!enable || issued == num_q) begin
              state <= ST_DRAIN;
            end else if (outstanding_nxt < MAX_O) begin
              read_req <= 1'b1;
              tr_adx   <= nxt_adx;
              nxt_adx  <= nxt_adx + STEP;
              issued   <= issued + ONE_C;
            end
          end
        end
        ST_DRAIN: begin
          if (!in_flight) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          pass_count <= pass_count + ONE_C;
          if (mode_q == MODE_LOOP && enable) begin
            state   <= ST_WRITE;
            nxt_adx <= base_adx;
            issued  <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_gen_checker.sv
// Directed bench for traffic_gen_checker with a delayed read-return memory model.
module tb_traffic_gen_checker;

  localparam int AW = 27;
  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] start_adx = '0;
  logic [CW-1:0] num_xfers = '0;
  logic          write_allowed = 1'b1;
  logic          read_allowed = 1'b1;
  logic          write_req;
  logic          read_req;
  logic [DW-1:0] tr_wr_data;
  logic [AW-1:0] tr_adx;
  logic          has_return_data = 1'b0;
  logic [DW-1:0] return_data = '0;
  logic [AW-1:0] return_adx = '0;
  logic          get_return_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_adx;
  logic [CW-1:0] pass_count;

  typedef struct {
    logic [AW-1:0] adx;
    int            rdy;
  } ret_t;

  ret_t          ret_q[$];
  logic [AW-1:0] wr_q[$];
  logic [AW-1:0] rd_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            delay = 2;
  int            n_done = 0;
  int            n_pop = 0;
  int            mdl_out = 0;
  int            max_out = 0;
  int            both_hi = 0;
  int            limit_viol = 0;
  logic          corrupt = 1'b0;
  logic [AW-1:0] corrupt_adx = '0;

  always #5 clk = ~clk;

  traffic_gen_checker dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .mode            (mode),
    .start_adx       (start_adx),
    .num_xfers       (num_xfers),
    .write_allowed   (write_allowed),
    .read_allowed    (read_allowed),
    .write_req       (write_req),
    .read_req        (read_req),
    .tr_wr_data      (tr_wr_data),
    .tr_adx          (tr_adx),
    .has_return_data (has_return_data),
    .return_data     (return_data),
    .return_adx      (return_adx),
    .get_return_data (get_return_data),
    .busy            (busy),
    .done            (done),
    .err_count       (err_count),
    .first_err_adx   (first_err_adx),
    .pass_count      (pass_count)
  );

  function automatic logic [DW-1:0] bpat(input logic [AW-1:0] a);
    logic [DW-1:0] p;
    for (int k = 0; k < DW/32; k++)
      p[k*32 +: 32] = 32'hA5A5_0000 ^ (32'(k) << 24) ^ 32'(a);
    return p;
  endfunction

  function automatic logic [DW-1:0] qget(input logic [AW-1:0] q[$], input int i);
    if (i < q.size()) return DW'(q[i]);
    return '1;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples handshakes at the falling edge, applies their effect just after the rising edge.
  task automatic tick();
    logic          s_wr, s_rd, s_pop;
    logic [AW-1:0] s_adx;
    logic [DW-1:0] s_data;
    int            s_out;
    @(negedge clk);
    s_wr   = write_req & write_allowed;
    s_rd   = read_req & read_allowed;
    s_pop  = get_return_data;
    s_adx  = tr_adx;
    s_data = tr_wr_data;
    s_out  = mdl_out;
    if (write_req && read_req) both_hi++;
    if (read_req && mdl_out >= 16) limit_viol++;
    if (done) n_done++;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      mdl_out = 0;
    end else begin
      if (s_wr) begin
        wr_q.push_back(s_adx);
        check("wr_data", s_data, bpat(s_adx));
      end
      if (s_rd) begin
        rd_q.push_back(s_adx);
        ret_q.push_back('{s_adx, cyc + delay});
        mdl_out++;
      end
      if (s_pop && s_out > 0) mdl_out--;
      if (mdl_out > max_out) max_out = mdl_out;
    end
    if (s_pop) begin
      void'(ret_q.pop_front());
      n_pop++;
    end
    if (ret_q.size() > 0 && ret_q[0].rdy <= cyc) begin
      has_return_data = 1'b1;
      return_adx      = ret_q[0].adx;
      return_data     = bpat(ret_q[0].adx) ^ DW'(corrupt && ret_q[0].adx == corrupt_adx);
    end else begin
      has_return_data = 1'b0;
    end
  endtask

  task automatic start_pass(input logic [1:0] m, input logic [AW-1:0] a, input logic [CW-1:0] n);
    mode      = m;
    start_adx = a;
    num_xfers = n;
    wr_q.delete();
    rd_q.delete();
    n_done  = 0;
    n_pop   = 0;
    max_out = 0;
    enable  = 1'b1;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int i = 0;
    while (done !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_in_time"}, DW'(i < budget), DW'(1));
    enable = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp1[4] = '{27'h100, 27'h108, 27'h110, 27'h118};
    int i;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", DW'({write_req, read_req, busy, done, get_return_data}), '0);
    check("rst_adx", DW'(tr_adx), '0);
    check("rst_data", tr_wr_data, '0);
    check("rst_cnt", DW'({err_count, pass_count, first_err_adx}), '0);
    reset = 1'b0;
    tick();

    // num_xfers 0: no traffic
    start_pass(2'd2, 27'h100, 16'd0);
    repeat (5) tick();
    check("zero_busy", DW'(busy), '0);
    check("zero_writes", DW'(wr_q.size()), '0);
    enable = 1'b0;
    tick();

    // Mode 2 basic pass
    start_pass(2'd2, 27'h100, 16'd4);
    run_until_done("t1", 200);
    check("t1_nwr", DW'(wr_q.size()), DW'(4));
    check("t1_nrd", DW'(rd_q.size()), DW'(4));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_wadx%0d", k), qget(wr_q, k), DW'(exp1[k]));
      check($sformatf("t1_radx%0d", k), qget(rd_q, k), DW'(exp1[k]));
    end
    check("t1_done", DW'(n_done), DW'(1));
    check("t1_err", DW'(err_count), '0);
    check("t1_pass", DW'(pass_count), DW'(1));
    check("t1_idle", DW'(busy), '0);

    // Mode 0 with write_allowed low for 5 cycles during the 2nd write
    start_pass(2'd0, 27'h200, 16'd4);
    i = 0;
    while (wr_q.size() < 1 && i < 50) begin
      tick();
      i++;
    end
    check("t2_first_wr", DW'(i < 50), DW'(1));
    write_allowed = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_hold_req", DW'(write_req), DW'(1));
      check("t2_hold_adx", DW'(tr_adx), DW'(27'h208));
      check("t2_hold_data", tr_wr_data, bpat(27'h208));
    end
    write_allowed = 1'b1;
    run_until_done("t2", 200);
    check("t2_nwr", DW'(wr_q.size()), DW'(4));
    check("t2_wadx1", qget(wr_q, 1), DW'(27'h208));
    check("t2_wadx3", qget(wr_q, 3), DW'(27'h218));
    check("t2_nrd", DW'(rd_q.size()), '0);
    check("t2_pass", DW'(pass_count), DW'(2));

    // Mode 1 with one corrupted return
    corrupt     = 1'b1;
    corrupt_adx = 27'h108;
    start_pass(2'd1, 27'h100, 16'd4);
    run_until_done("t3", 200);
    corrupt = 1'b0;
    check("t3_err", DW'(err_count), DW'(1));
    check("t3_first_err", DW'(first_err_adx), DW'(27'h108));
    check("t3_nrd", DW'(rd_q.size()), DW'(4));
    check("t3_nwr", DW'(wr_q.size()), '0);
    check("t3_pass", DW'(pass_count), DW'(3));

    // Mode 1, 40 reads, 50-cycle return latency: outstanding limit
    delay = 50;
    start_pass(2'd1, 27'h1000, 16'd40);
    run_until_done("t4", 1000);
    delay = 2;
    check("t4_max_out", DW'(max_out), DW'(16));
    check("t4_limit", DW'(limit_viol), '0);
    check("t4_nrd", DW'(rd_q.size()), DW'(40));
    check("t4_npop", DW'(n_pop), DW'(40));
    check("t4_left", DW'(ret_q.size()), '0);
    check("t4_err", DW'(err_count), '0);
    check("t4_pass", DW'(pass_count), DW'(4));

    // Mode 3 loop, enable dropped two writes into pass 3
    start_pass(2'd3, 27'h300, 16'd4);
    i = 0;
    while (n_done < 2 && i < 300) begin
      tick();
      i++;
    end
    check("t5_two_passes", DW'(i < 300), DW'(1));
    repeat (3) tick();
    enable = 1'b0;
    i = 0;
    while (busy && i < 300) begin
      tick();
      i++;
    end
    tick();
    check("t5_done", DW'(n_done), DW'(3));
    check("t5_pass", DW'(pass_count), DW'(7));
    check("t5_idle", DW'(busy), '0);
    check("t5_nwr", DW'(wr_q.size()), DW'(11));
    check("t5_nrd", DW'(rd_q.size()), DW'(8));
    check("t5_restart", qget(wr_q, 8), DW'(27'h300));
    check("t5_err", DW'(err_count), '0);

    // Address wrap
    start_pass(2'd2, 27'h7FF_FFF8, 16'd2);
    run_until_done("t6", 200);
    check("t6_wadx0", qget(wr_q, 0), DW'(27'h7FF_FFF8));
    check("t6_wadx1", qget(wr_q, 1), '0);
    check("t6_radx1", qget(rd_q, 1), '0);
    check("t6_err", DW'(err_count), '0);
    check("t6_pass", DW'(pass_count), DW'(8));

    // Reset mid-READ with exactly one read in flight
    delay = 20;
    start_pass(2'd1, 27'h400, 16'd8);
    i = 0;
    while (rd_q.size() < 1 && i < 50) begin
      tick();
      i++;
    end
    check("t7_first_rd", DW'(i < 50), DW'(1));
    read_allowed = 1'b0;
    tick();
    check("t7_in_read", DW'({busy, read_req}), DW'(2'b11));
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("t7_rst_ctl", DW'({write_req, read_req, busy, done, get_return_data}), '0);
    check("t7_rst_cnt", DW'({err_count, pass_count, first_err_adx}), '0);
    check("t7_rst_adx", DW'(tr_adx), '0);
    tick();
    tick();
    reset        = 1'b0;
    read_allowed = 1'b1;
    repeat (40) tick();
    check("t7_err", DW'(err_count), DW'(1));
    check("t7_first_err", DW'(first_err_adx), DW'(27'h400));
    check("t7_left", DW'(ret_q.size()), '0);
    check("t7_idle", DW'(busy), '0);
    check("t7_pass", DW'(pass_count), '0);

    check("never_both_req", DW'(both_hi), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
